// File: rtl/content_loss_sequencer.sv
// Streams two feature maps one pixel pair per cycle and accumulates the squared
// differences; loss = sum/2. Optional `CONTENT_LOSS_MEAN_EN divides by the pixel count.
module content_loss_sequencer #(
  parameter int N_PIX  = 1024,
  parameter int PIX_W  = 16,
  parameter int ADDR_W = $clog2(N_PIX),
  parameter int ACC_W  = 2*(PIX_W+1)-1+$clog2(N_PIX),
  parameter int OUT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [PIX_W-1:0]  content_pix,
  input  logic [PIX_W-1:0]  generated_pix,
  output logic [OUT_W-1:0]  loss_out,
  output logic [ACC_W-1:0]  loss_full,
  output logic              loss_sat
);

  localparam int SQ_W = 2*(PIX_W+1)-1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_PIX-1);

`ifdef CONTENT_LOSS_MEAN_EN
  localparam int MEAN_SH = $clog2(N_PIX);
  if ((1 << $clog2(N_PIX)) != N_PIX) begin : g_pow2_check
    $error("content_loss_sequencer: N_PIX must be a power of two for mean normalisation");
  end
`else
  localparam int MEAN_SH = 0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t state, state_nxt;

  logic                    vld_p0, vld_p1, vld_p2;
  logic signed [PIX_W:0]   diff_p1;
  logic signed [SQ_W-1:0]  diff_ext;
  logic        [SQ_W-1:0]  sq_p2;
  logic        [ACC_W-1:0] acc_p3;
  logic        [ACC_W-1:0] full_nxt;
  logic                    latch_res;

  function automatic logic [OUT_W-1:0] sat_loss(input logic [ACC_W-1:0] v);
    if (|v[ACC_W-1:OUT_W]) return {OUT_W{1'b1}};
    return v[OUT_W-1:0];
  endfunction

  function automatic logic is_sat(input logic [ACC_W-1:0] v);
    return |v[ACC_W-1:OUT_W];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (rd_addr == LAST_ADDR) state_nxt = S_DRAIN;
      S_DRAIN: if (!(vld_p0 || vld_p1 || vld_p2)) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy  = 1'b0;
    rd_en = 1'b0;
    done  = 1'b0;
    case (state)
      S_RUN:   begin busy = 1'b1; rd_en = 1'b1; end
      S_DRAIN: busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Address counter saturates at the last pixel instead of wrapping
  always_ff @(posedge clk) begin
    if (rst)                                   rd_addr <= '0;
    else if (state == S_IDLE && start)         rd_addr <= '0;
    else if (state == S_RUN && rd_addr != LAST_ADDR) rd_addr <= rd_addr + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      vld_p0 <= rd_en;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
    end
  end

  // p1: buffer data -> signed difference
  always_ff @(posedge clk) begin
    diff_p1 <= $signed({content_pix[PIX_W-1], content_pix})
             - $signed({generated_pix[PIX_W-1], generated_pix});
  end

  // p2: difference -> square (always non-negative, fits SQ_W unsigned)
  assign diff_ext = {{(SQ_W-PIX_W-1){diff_p1[PIX_W]}}, diff_p1};

  always_ff @(posedge clk) begin
    sq_p2 <= $unsigned(diff_ext * diff_ext);
  end

  // p3: accumulate
  always_ff @(posedge clk) begin
    if (rst)                           acc_p3 <= '0;
    else if (state == S_IDLE && start) acc_p3 <= '0;
    else if (vld_p2)                   acc_p3 <= acc_p3 + ACC_W'(sq_p2);
  end

  // Result is captured on entry to DONE so it is already valid while done is high
  assign full_nxt  = (acc_p3 >> 1) >> MEAN_SH;
  assign latch_res = (state == S_DRAIN) && (state_nxt == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      loss_full <= '0;
      loss_out  <= '0;
      loss_sat  <= 1'b0;
    end else if (latch_res) begin
      loss_full <= full_nxt;
      loss_out  <= sat_loss(full_nxt);
      loss_sat  <= is_sat(full_nxt);
    end
  end

endmodule

// File: doc/content_loss_sequencer.md
Name: content_loss_sequencer

Overview:
- Streams a content feature map and a generated feature map out of two pixel buffers, one pixel pair per cycle.
- Computes the sum of squared differences and emits loss = sum/2.
- Sits between the feature-map BRAMs and the style-transfer optimiser, which pulses start and waits for done.
- Replaces the fully parallel 1024-way loss evaluation with a pipelined single-MAC datapath.

Parameters:
N_PIX, 1024, pixels per map (>= 2)
PIX_W, 16, pixel width, signed two's complement
ADDR_W, $clog2(N_PIX), buffer address width
ACC_W, 2*(PIX_W+1)-1+$clog2(N_PIX) (=43), accumulator width, sized so it never overflows
OUT_W, 16, width of saturated loss output

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start  in  1  request a loss computation; sampled only in IDLE
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse; loss outputs valid from this cycle on
rd_en  out  1  buffer read enable (shared by both buffers)
rd_addr  out  ADDR_W  buffer read address (shared)
content_pix  in  PIX_W  content buffer read data, valid 1 cycle after rd_en
generated_pix  in  PIX_W  generated buffer read data, valid 1 cycle after rd_en
loss_out  out  OUT_W  saturated loss
loss_full  out  ACC_W  unsaturated loss (sum >> 1)
loss_sat  out  1  high when loss_full > 2^OUT_W-1

Behaviour:
- Reset: state IDLE; busy, done, rd_en, loss_sat = 0; rd_addr, loss_out, loss_full, accumulator, pipeline valids = 0. Reset overrides everything, including mid-RUN/DRAIN; the in-flight result is discarded and done is not pulsed.
- States:
  - IDLE: start=1 -> RUN; clear accumulator, address counter = 0.
  - RUN: rd_en=1, rd_addr = counter, counter++ each cycle; after issuing address N_PIX-1 -> DRAIN.
  - DRAIN: rd_en=0; wait until the pipeline valid chain empties -> DONE.
  - DONE: done=1 for exactly this cycle; latch loss_full/loss_out/loss_sat -> IDLE.
- Pipeline, with a valid bit per stage:
  - E+1: buffer returns data.
  - E+2: diff = content_pix - generated_pix, 17-bit signed register.
  - E+3: sq = diff*diff, 2*(PIX_W+1)-1 = 33-bit unsigned register.
  - E+4: acc += sq.
- Latency: done is high in the cycle following the (N_PIX+4)th rising edge after the edge that sampled start (1028 for default). rd_en is high for exactly N_PIX consecutive cycles.
- Outputs: loss_full = acc >> 1, i.e. floor(sum/2). loss_out = loss_full if < 2^OUT_W, else all-ones with loss_sat=1. Outputs hold until the next DONE or reset.
- Handshake: start ignored while busy (no queuing). start held high in IDLE after DONE begins a new run in the next cycle; done and the new start acceptance may coincide only as DONE -> IDLE -> RUN (no skip).
- Address never wraps: the counter stops at N_PIX-1.

Optional Feature:
CONTENT_LOSS_MEAN_EN
- Defined: loss_full = (acc >> 1) >> $clog2(N_PIX), i.e. loss normalised by pixel count. N_PIX must be a power of two; an elaboration-time assertion fails otherwise. Saturation applies after the shift. Latency is unchanged.
- Undefined: loss_full = acc >> 1 as above.

Test Plan:
- Identical maps (random data in both buffers), default params, start pulse -> done at edge N_PIX+4 = 1028 after start; loss_out=0, loss_full=0, loss_sat=0; rd_en high for exactly 1024 cycles, addresses 0..1023 in order.
- All content=3, all generated=1 -> sum 4096; loss_full=2048, loss_out=0x0800, loss_sat=0. With CONTENT_LOSS_MEAN_EN: loss_full=2, loss_out=0x0002.
- N_PIX=4; content=1,2,3,4, generated=0 -> squares 1,4,9,16, sum 30; loss_out=15, done 8 edges after start. Re-run with diffs 1,1,1,0 (sum 3) -> loss_out=1 (floor).
- All content=32767, all generated=-32768 -> diff 65535, sq 4294836225 per pixel; loss_full = 1024*4294836225/2 = 2198956147200; loss_out=0xFFFF, loss_sat=1; no accumulator wrap.
- start re-pulsed at cycles 5 and 500 of a run -> ignored, single done, result equals an undisturbed run. start held high continuously -> back-to-back runs, each done followed by IDLE for one cycle.
- rst asserted at cycle 300 of a run -> next cycle busy=0, rd_en=0, loss outputs 0, no done pulse; a fresh start then gives the correct result with no residue from the aborted run.
